// File: rtl/conv_if.sv
// Word-addressed BRAM port: one-cycle synchronous read, byte-enabled write.
// The engine is the master on all three of its memory ports.
interface conv_if;
  logic        R_req;
  logic [31:0] addr;
  logic [31:0] R_data;
  logic [3:0]  W_req;
  logic [31:0] W_data;

  modport master (output R_req, addr, W_req, W_data, input R_data);
  modport slave  (input R_req, addr, W_req, W_data, output R_data);
endinterface

// File: rtl/conv.sv
// Fixed-kernel 3x3 two-channel convolution: loads a 28x28 image from m0,
// writes 26x26 clamped results for channel 0 to m1 and channel 1 to m2.
module conv #(
  parameter logic [71:0]        K0    = 72'h00_00_00_00_01_00_00_00_00,
  parameter logic [71:0]        K1    = 72'h01_01_01_01_01_01_01_01_01,
  parameter logic signed [15:0] B0    = 16'sd0,
  parameter logic signed [15:0] B1    = 16'sd0,
  parameter int unsigned        SHIFT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic finish,
  conv_if.master m0,
  conv_if.master m1,
  conv_if.master m2
);

  typedef enum logic [1:0] {IDLE, LOAD, COMP, DONE} state_t;

  localparam logic [7:0] LAST_IN_WORD = 8'd195;
  localparam logic [9:0] LAST_OUT_PIX = 10'd675;

  state_t      state;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        cap_vld;
  logic [7:0]  cap_idx;
  logic [4:0]  row;
  logic [4:0]  col;
  logic [9:0]  o_idx;
  logic [23:0] pack0;
  logic [23:0] pack1;
  logic [3:0]  wr_req;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data0;
  logic [31:0] wr_data1;

  logic [7:0]  img [0:783];
  logic [9:0]  base;
  logic [71:0] win;
  logic [7:0]  y0;
  logic [7:0]  y1;

  // Weight n (row-major) and window pixel n share the same byte packing:
  // element 0 in the top byte, element 8 in the bottom byte.
  function automatic logic [7:0] conv_px(input logic [71:0] px,
                                         input logic [71:0] k,
                                         input logic signed [15:0] b);
    logic signed [20:0] acc;
    logic signed [7:0]  w;
    logic [7:0]         x;
    acc = 21'(b);
    for (int n = 0; n < 9; n++) begin
      x   = px[8*(8-n) +: 8];
      w   = k[8*(8-n) +: 8];
      acc = acc + 21'($signed({1'b0, x})) * 21'(w);
    end
    acc = acc >>> SHIFT;
    if (acc < 0)
      return 8'h00;
    else if (acc > 21'sd255)
      return 8'hFF;
    else
      return acc[7:0];
  endfunction

  assign base = 10'(row) * 10'd28 + 10'(col);

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (here unconditionally), otherwise synthesis infers a latch.
  always_comb begin
    win = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        win[8*(8-(3*i+j)) +: 8] = img[base + 10'(28*i + j)];
  end

  assign y0 = conv_px(win, K0, B0);
  assign y1 = conv_px(win, K1, B1);

  // NOTE: the image buffer has no reset; it is fully rewritten by LOAD before
  // COMP reads it, and leaving it out of reset keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (cap_vld)
      for (int k = 0; k < 4; k++)
        img[{cap_idx, 2'b00} + 10'(k)] <= m0.R_data[8*(3-k) +: 8];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
      cap_vld  <= 1'b0;
      cap_idx  <= '0;
      row      <= '0;
      col      <= '0;
      o_idx    <= '0;
      pack0    <= '0;
      pack1    <= '0;
      wr_req   <= '0;
      wr_addr  <= '0;
      wr_data0 <= '0;
      wr_data1 <= '0;
      finish   <= 1'b0;
    end else begin
      // Read data arrives one cycle after the request edge.
      cap_vld <= rd_req;
      cap_idx <= rd_addr;
      wr_req  <= '0;

      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            rd_req  <= 1'b1;
            rd_addr <= '0;
          end
        end

        LOAD: begin
          if (rd_req) begin
            if (rd_addr == LAST_IN_WORD)
              rd_req <= 1'b0;
            else
              rd_addr <= rd_addr + 8'd1;
          end
          if (cap_vld && cap_idx == LAST_IN_WORD) begin
            state <= COMP;
            row   <= '0;
            col   <= '0;
            o_idx <= '0;
          end
        end

        COMP: begin
          pack0 <= {pack0[15:0], y0};
          pack1 <= {pack1[15:0], y1};
          if (o_idx[1:0] == 2'd3) begin
            wr_req   <= 4'hF;
            wr_addr  <= o_idx[9:2];
            wr_data0 <= {pack0, y0};
            wr_data1 <= {pack1, y1};
          end
          if (o_idx == LAST_OUT_PIX) begin
            state <= DONE;
          end else begin
            o_idx <= o_idx + 10'd1;
            if (col == 5'd25) begin
              col <= '0;
              row <= row + 5'd1;
            end else begin
              col <= col + 5'd1;
            end
          end
        end

        DONE: begin
          // The final write is on the bus during the first DONE cycle, so
          // finish rises only after that write edge.
          finish <= 1'b1;
          if (start) begin
            finish  <= 1'b0;
            state   <= LOAD;
            rd_req  <= 1'b1;
            rd_addr <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign m0.R_req  = rd_req;
  assign m0.addr   = {24'd0, rd_addr};
  assign m0.W_req  = '0;
  assign m0.W_data = '0;

  assign m1.R_req  = 1'b0;
  assign m1.addr   = {24'd0, wr_addr};
  assign m1.W_req  = wr_req;
  assign m1.W_data = wr_data0;

  assign m2.R_req  = 1'b0;
  assign m2.addr   = {24'd0, wr_addr};
  assign m2.W_req  = wr_req;
  assign m2.W_data = wr_data1;

  logic unused_rdata;
  assign unused_rdata = ^{m1.R_data, m2.R_data};

endmodule

// File: tb/tb_conv.sv
// Scoreboard bench for conv: jobs push expected M1/M2 writes into a queue,
// a negedge monitor pops and compares each write the engine issues.
module tb_conv;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic finish;

  conv_if m0();
  conv_if m1();
  conv_if m2();

  conv dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .finish (finish),
    .m0     (m0),
    .m1     (m1),
    .m2     (m2)
  );

  always #5 clk = ~clk;

  // Input image BRAM with one-cycle synchronous read.
  logic [31:0] mem0 [0:255];
  always @(posedge clk) begin
    if (m0.R_req) m0.R_data <= mem0[m0.addr[7:0]];
  end
  assign m1.R_data = '0;
  assign m2.R_data = '0;

  typedef enum {PAT_ZERO, PAT_UNI, PAT_DOT} pat_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   prot_viol = 0;
  int   finish_rises = 0;
  logic finish_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] img_word(input pat_t p, input logic [7:0] v, input int w);
    case (p)
      PAT_UNI: return {4{v}};
      PAT_DOT: return (w == 7) ? 32'h00C80000 : 32'h0;  // pixel 29 = (1,1)
      default: return 32'h0;
    endcase
  endfunction

  // Channel 0 default kernel passes the window centre through.
  function automatic logic [31:0] exp1(input pat_t p, input logic [7:0] v, input int w);
    case (p)
      PAT_UNI: return {4{v}};
      PAT_DOT: return (w == 0) ? 32'hC8000000 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // Channel 1 sums the 3x3 window; a pixel at (1,1) only reaches outputs
  // (0,0),(0,1),(1,0),(1,1) = o 0,1,26,27.
  function automatic logic [31:0] exp2(input pat_t p, input logic [7:0] v, input int w);
    int s;
    logic [7:0] b;
    case (p)
      PAT_UNI: begin
        s = 9 * int'(v);
        b = (s > 255) ? 8'hFF : 8'(s);
        return {4{b}};
      end
      PAT_DOT: begin
        if (w == 0) return 32'hC8C80000;
        if (w == 6) return 32'h0000C8C8;
        return 32'h0;
      end
      default: return 32'h0;
    endcase
  endfunction

  // Monitor: protocol watch, finish edge count, and write scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (m0.W_req !== 4'h0 || m0.W_data !== 32'h0 || m1.R_req !== 1'b0 || m2.R_req !== 1'b0)
      prot_viol++;
    if (finish === 1'b1 && finish_q !== 1'b1) finish_rises++;
    finish_q = finish;
    if (m1.W_req !== 4'h0 || m2.W_req !== 4'h0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %08h got w_req %h/%h with no write expected",
                 m1.addr, m1.W_req, m2.W_req);
      end else begin
        e = exp_q.pop_front();
        check("m1_w_req", 32'(m1.W_req), 32'hF);
        check("m2_w_req", 32'(m2.W_req), 32'hF);
        check("m1_addr", m1.addr, e.addr);
        check("m2_addr", m2.addr, e.addr);
        check("m1_data", m1.W_data, e.d1);
        check("m2_data", m2.W_data, e.d2);
        if (exp_q.size() == 0) check("finish_low_at_last_write", 32'(finish), 32'h0);
      end
    end
  end

  task automatic load_job(input pat_t p, input logic [7:0] v);
    for (int w = 0; w < 196; w++) mem0[w] = img_word(p, v, w);
    for (int w = 0; w < 169; w++)
      exp_q.push_back('{addr: 32'(w), d1: exp1(p, v, w), d2: exp2(p, v, w)});
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("first_read_req", 32'(m0.R_req), 32'h1);
    check("first_read_addr", m0.addr, 32'h0);
    check("finish_cleared", 32'(finish), 32'h0);
  endtask

  task automatic run_job(input pat_t p, input logic [7:0] v, input bit restart_mid);
    int cyc;
    load_job(p, v);
    prot_viol = 0;
    finish_rises = 0;
    pulse_start();
    cyc = 1;
    while (finish !== 1'b1 && cyc < 900) begin
      start = (restart_mid && cyc == 450) ? 1'b1 : 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("finish_raised", 32'(finish), 32'h1);
    check("finish_within_880", 32'(cyc <= 880), 32'h1);
    repeat (5) @(negedge clk);
    check("finish_held", 32'(finish), 32'h1);
    check("all_writes_seen", 32'(exp_q.size()), 32'h0);
    check("finish_single_rise", 32'(finish_rises), 32'h1);
    check("unused_ports_quiet", 32'(prot_viol), 32'h0);
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_finish"}, 32'(finish), 32'h0);
    check({tag, "_m0_r_req"}, 32'(m0.R_req), 32'h0);
    check({tag, "_m0_addr"}, m0.addr, 32'h0);
    check({tag, "_m1_w_req"}, 32'(m1.W_req), 32'h0);
    check({tag, "_m1_addr"}, m1.addr, 32'h0);
    check({tag, "_m1_w_data"}, m1.W_data, 32'h0);
    check({tag, "_m2_w_req"}, 32'(m2.W_req), 32'h0);
    check({tag, "_m2_w_data"}, m2.W_data, 32'h0);
  endtask

  initial begin
    for (int w = 0; w < 256; w++) mem0[w] = 32'h0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_job(PAT_ZERO, 8'd0, 1'b0);
    run_job(PAT_UNI, 8'd10, 1'b1);   // extra start mid-COMP must be ignored
    run_job(PAT_DOT, 8'd0, 1'b0);
    run_job(PAT_UNI, 8'd255, 1'b0);

    // Abort mid-COMP: outputs clear at once and no further writes appear.
    load_job(PAT_UNI, 8'd10);
    pulse_start();
    repeat (300) @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs_zero("abort");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_idle_finish", 32'(finish), 32'h0);

    run_job(PAT_DOT, 8'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
